uart_frame_decoder: RTL
=======================

# uart_frame_decoder

Byte-stream frame parser directly downstream of the UART receiver. Consumes received bytes, delineates frames (sync, command, length, payload, XOR checksum), buffers one validated frame, and presents it to the control firmware bridge through a valid/ready handshake with a random-access payload read port. Malformed, oversize, stalled or unconsumed-collision traffic is discarded and reported by single-cycle error pulses.

## Interface
- MAX_LEN, 16: maximum payload bytes per frame (1..255).
- SYNC_BYTE, 8'hAA: frame start marker.
- TIMEOUT_CYCLES, 50000: inter-byte gap limit in clk cycles (1 ms at 50 MHz).
- LW: localparam, $clog2(MAX_LEN+1); width of length and address fields.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- rx_byte  in  8  received byte from UART.
- rx_valid  in  1  one-cycle strobe; rx_byte valid this cycle.
- frm_valid  out  1  validated frame held for the consumer.
- frm_ready  in  1  consumer accepts frame (handshake when both high).
- frm_cmd  out  8  command byte of held frame.
- frm_len  out  LW  payload length of held frame.
- pld_addr  in  LW  payload read index.
- pld_data  out  8  payload byte at pld_addr (combinational from buffer; 0 if pld_addr >= frm_len).
- err_csum  out  1  pulse: checksum mismatch.
- err_len  out  1  pulse: LEN > MAX_LEN.
- err_timeout  out  1  pulse: inter-byte gap exceeded.
- byte_drop  out  1  pulse: byte discarded while a frame is held.

## Operation
- Frame: SYNC_BYTE, CMD, LEN, LEN payload bytes, CSUM. CSUM = CMD ^ LEN ^ all payload bytes.
- States: S_HUNT, S_CMD, S_LEN, S_PLD, S_CSUM, S_HOLD. All transitions occur only on rx_valid unless stated.
- S_HUNT: byte == SYNC_BYTE -> S_CMD; other bytes ignored silently.
- S_CMD: store CMD, init running XOR = CMD -> S_LEN.
- S_LEN: LEN > MAX_LEN -> err_len, S_HUNT. LEN == 0 -> S_CSUM. Else store LEN, clear write index -> S_PLD. XOR updated with LEN.
- S_PLD: write byte at index, XOR update, index increments; after LEN-th byte -> S_CSUM.
- S_CSUM: byte == XOR -> latch cmd/len into output registers, S_HOLD, frm_valid=1. Mismatch -> err_csum, S_HUNT.
- SYNC_BYTE value inside CMD/LEN/payload/CSUM is ordinary data; no mid-frame resync.
- S_HOLD: frm_valid high; frm_cmd, frm_len, payload stable. frm_valid && frm_ready -> S_HUNT next cycle. Any rx_valid while in S_HOLD (including the handshake cycle) -> byte discarded, byte_drop pulses.
- Payload buffer: MAX_LEN x 8, written only in S_PLD; overwritten by next frame only after handshake.

## Timing
- Reset: state S_HUNT; frm_valid, frm_cmd, frm_len, all error pulses, byte_drop = 0; buffer contents undefined (pld_data masked to 0 because frm_len = 0).
- All state updates registered; error pulses and byte_drop are exactly one cycle, the cycle after the offending rx_valid.
- frm_valid rises the cycle after the CSUM byte's rx_valid; falls the cycle after handshake.
- frm_ready ignored when frm_valid low.
- pld_data: zero-latency combinational read.
- Reset mid-frame: partial frame discarded, no error pulse.

## Configuration
- UART_FRAME_TIMEOUT_EN defined: gap counter clears on every rx_valid, counts in S_CMD..S_CSUM; reaching TIMEOUT_CYCLES-1 without a byte -> err_timeout pulse, S_HUNT. Counter idle in S_HUNT/S_HOLD.
- Undefined: no counter logic; err_timeout tied 0; partial frame waits indefinitely.

## Structure
- Package uart_frame_pkg: state enum, default SYNC_BYTE, default MAX_LEN, helper for LW.
- One sub-module natural: uart_frame_buf (MAX_LEN x 8 register file, one synchronous write port, one combinational read port). Parser FSM, XOR and timeout counter in top.

## Test plan
- Bytes AA 10 02 55 66 (CSUM 10^02^55^66 = 21) then 21 -> frm_valid next cycle, cmd 0x10, len 2, pld[0]=55, pld[1]=66; ready pulse -> frm_valid low.
- AA 10 02 55 66 00 -> err_csum single pulse, frm_valid stays 0; following valid frame accepted normally.
- AA 10 11 (MAX_LEN=16) -> err_len pulse, back to hunt; AA 20 00 20 -> zero-length frame, cmd 0x20, len 0.
- Frame held, ready low, send 3 bytes -> 3 byte_drop pulses, held frame unchanged; payload AA inside frame parsed as data.
- With UART_FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=100: AA 10 then 100 idle cycles -> err_timeout once; without macro -> no pulse, frame completes later.
- Assert rst after AA 10 02 55 -> all outputs 0, next full frame decoded correctly.

Source files
------------

// File: rtl/uart_frame_decoder_pkg.sv
// Shared types and defaults for the UART frame decoder slice.
package uart_frame_pkg;

    typedef enum logic [2:0] {
        S_HUNT,
        S_CMD,
        S_LEN,
        S_PLD,
        S_CSUM,
        S_HOLD
    } state_t;

    localparam int         DEFAULT_MAX_LEN        = 16;
    localparam logic [7:0] DEFAULT_SYNC_BYTE      = 8'hAA;
    localparam int         DEFAULT_TIMEOUT_CYCLES = 50000;

    // Width needed to hold a length in 0..max_len.
    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Width needed to index a buffer of max_len entries.
    function automatic int addr_width(input int max_len);
        return (max_len > 1) ? $clog2(max_len) : 1;
    endfunction

endpackage

// File: rtl/uart_frame_decoder_if.sv
// Byte input, frame handshake and payload read port of the UART frame decoder.
interface uart_frame_decoder_if #(
    parameter int MAX_LEN = uart_frame_pkg::DEFAULT_MAX_LEN
);
    localparam int LW = uart_frame_pkg::len_width(MAX_LEN);

    logic [7:0]    rx_byte;
    logic          rx_valid;
    logic          frm_valid;
    logic          frm_ready;
    logic [7:0]    frm_cmd;
    logic [LW-1:0] frm_len;
    logic [LW-1:0] pld_addr;
    logic [7:0]    pld_data;
    logic          err_csum;
    logic          err_len;
    logic          err_timeout;
    logic          byte_drop;

    // Environment side: UART receiver plus firmware bridge.
    modport master (
        output rx_byte, rx_valid, frm_ready, pld_addr,
        input  frm_valid, frm_cmd, frm_len, pld_data,
        input  err_csum, err_len, err_timeout, byte_drop
    );

    // Decoder side.
    modport slave (
        input  rx_byte, rx_valid, frm_ready, pld_addr,
        output frm_valid, frm_cmd, frm_len, pld_data,
        output err_csum, err_len, err_timeout, byte_drop
    );

endinterface

// File: rtl/uart_frame_decoder_buf.sv
// Payload register file: one synchronous write port, one combinational read port.
module uart_frame_buf
    import uart_frame_pkg::*;
#(
    parameter int MAX_LEN = DEFAULT_MAX_LEN,
    parameter int LW      = len_width(MAX_LEN),
    parameter int AW      = addr_width(MAX_LEN)
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [LW-1:0] rd_addr,
    output logic [7:0]    rd_data
);

    logic [7:0] mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Out-of-range reads return zero rather than aliasing onto a real entry.
    assign rd_data = (rd_addr < LW'(MAX_LEN)) ? mem[rd_addr[AW-1:0]] : 8'h00;

endmodule

// File: rtl/uart_frame_decoder.sv
// UART frame parser (SYNC, CMD, LEN, payload, XOR checksum) holding one validated frame.
// Defining UART_FRAME_TIMEOUT_EN adds the inter-byte gap timeout.
module uart_frame_decoder
    import uart_frame_pkg::*;
#(
    parameter int         MAX_LEN        = DEFAULT_MAX_LEN,
    parameter logic [7:0] SYNC_BYTE      = DEFAULT_SYNC_BYTE,
    parameter int         TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input logic                 clk,
    input logic                 rst,
    uart_frame_decoder_if.slave bus
);

    localparam int         LW        = len_width(MAX_LEN);
    localparam int         AW        = addr_width(MAX_LEN);
    localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

    state_t        state;
    state_t        state_n;
    logic [7:0]    cmd_q;
    logic [7:0]    cmd_n;
    logic [LW-1:0] len_q;
    logic [LW-1:0] len_n;
    logic [LW-1:0] idx_q;
    logic [LW-1:0] idx_n;
    logic [LW-1:0] idx_inc;
    logic [7:0]    xor_q;
    logic [7:0]    xor_n;
    logic [7:0]    frm_cmd_q;
    logic [7:0]    frm_cmd_n;
    logic [LW-1:0] frm_len_q;
    logic [LW-1:0] frm_len_n;
    logic          err_csum_q;
    logic          err_csum_n;
    logic          err_len_q;
    logic          err_len_n;
    logic          byte_drop_q;
    logic          byte_drop_n;
    logic          wr_en;
    logic [7:0]    buf_rd_data;
    logic          timeout_hit;

    assign idx_inc = idx_q + LW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_HUNT;
            cmd_q       <= 8'h00;
            len_q       <= '0;
            idx_q       <= '0;
            xor_q       <= 8'h00;
            frm_cmd_q   <= 8'h00;
            frm_len_q   <= '0;
            err_csum_q  <= 1'b0;
            err_len_q   <= 1'b0;
            byte_drop_q <= 1'b0;
        end else begin
            state       <= state_n;
            cmd_q       <= cmd_n;
            len_q       <= len_n;
            idx_q       <= idx_n;
            xor_q       <= xor_n;
            frm_cmd_q   <= frm_cmd_n;
            frm_len_q   <= frm_len_n;
            err_csum_q  <= err_csum_n;
            err_len_q   <= err_len_n;
            byte_drop_q <= byte_drop_n;
        end
    end

    // Sync values seen after S_HUNT are plain data; there is no mid-frame resync.
    always_comb begin
        state_n     = state;
        cmd_n       = cmd_q;
        len_n       = len_q;
        idx_n       = idx_q;
        xor_n       = xor_q;
        frm_cmd_n   = frm_cmd_q;
        frm_len_n   = frm_len_q;
        err_csum_n  = 1'b0;
        err_len_n   = 1'b0;
        byte_drop_n = 1'b0;
        wr_en       = 1'b0;
        unique case (state)
            S_HUNT: begin
                if (bus.rx_valid && (bus.rx_byte == SYNC_BYTE)) begin
                    state_n = S_CMD;
                end
            end
            S_CMD: begin
                if (bus.rx_valid) begin
                    cmd_n   = bus.rx_byte;
                    xor_n   = bus.rx_byte;
                    state_n = S_LEN;
                end
            end
            S_LEN: begin
                if (bus.rx_valid) begin
                    if (bus.rx_byte > MAX_LEN_B) begin
                        err_len_n = 1'b1;
                        state_n   = S_HUNT;
                    end else begin
                        len_n   = bus.rx_byte[LW-1:0];
                        idx_n   = '0;
                        xor_n   = xor_q ^ bus.rx_byte;
                        state_n = (bus.rx_byte == 8'h00) ? S_CSUM : S_PLD;
                    end
                end
            end
            S_PLD: begin
                if (bus.rx_valid) begin
                    wr_en = 1'b1;
                    xor_n = xor_q ^ bus.rx_byte;
                    idx_n = idx_inc;
                    if (idx_inc == len_q) begin
                        state_n = S_CSUM;
                    end
                end
            end
            S_CSUM: begin
                if (bus.rx_valid) begin
                    if (bus.rx_byte == xor_q) begin
                        frm_cmd_n = cmd_q;
                        frm_len_n = len_q;
                        state_n   = S_HOLD;
                    end else begin
                        err_csum_n = 1'b1;
                        state_n    = S_HUNT;
                    end
                end
            end
            S_HOLD: begin
                byte_drop_n = bus.rx_valid;
                if (bus.frm_ready) begin
                    state_n = S_HUNT;
                end
            end
            default: state_n = S_HUNT;
        endcase
        if (timeout_hit) begin
            state_n = S_HUNT;
        end
    end

`ifdef UART_FRAME_TIMEOUT_EN
    localparam int            CW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] GAP_LIMIT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] gap_cnt;
    logic          gap_active;
    logic          err_timeout_q;

    assign gap_active  = (state == S_CMD) || (state == S_LEN) ||
                         (state == S_PLD) || (state == S_CSUM);
    assign timeout_hit = gap_active && !bus.rx_valid && (gap_cnt == GAP_LIMIT);

    // Gap counter only runs while a frame is partially received.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_cnt       <= '0;
            err_timeout_q <= 1'b0;
        end else begin
            err_timeout_q <= timeout_hit;
            if (!gap_active || bus.rx_valid || timeout_hit) begin
                gap_cnt <= '0;
            end else begin
                gap_cnt <= gap_cnt + CW'(1);
            end
        end
    end

    assign bus.err_timeout = err_timeout_q;
`else
    assign timeout_hit     = 1'b0;
    assign bus.err_timeout = 1'b0;
`endif

    uart_frame_buf #(
        .MAX_LEN (MAX_LEN),
        .LW      (LW),
        .AW      (AW)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (idx_q[AW-1:0]),
        .wr_data (bus.rx_byte),
        .rd_addr (bus.pld_addr),
        .rd_data (buf_rd_data)
    );

    assign bus.frm_valid = (state == S_HOLD);
    assign bus.frm_cmd   = frm_cmd_q;
    assign bus.frm_len   = frm_len_q;
    assign bus.pld_data  = (bus.pld_addr < frm_len_q) ? buf_rd_data : 8'h00;
    assign bus.err_csum  = err_csum_q;
    assign bus.err_len   = err_len_q;
    assign bus.byte_drop = byte_drop_q;

endmodule
